cardinal_dmem: RTL and testbench

- Single-port 64-bit data memory that consumes the processor's data-memory interface: Mem_Addr, Data_Out, DmemEn and DmemWrEn.
- Returns load data on Data_In.
- Contains a scrub FSM that initialises every word after reset, or on request. While scrubbing it raises Dmem_Busy so the pipeline can hold off memory traffic.
- Sits directly downstream of the processor's ID/EX-MEM stage, on the DMEM side of the core.

---
 rtl/cardinal_dmem_if.sv | 27 ++
 rtl/cardinal_dmem.sv | 109 ++++++++++
 tb/tb_cardinal_dmem.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cardinal_dmem_if.sv
// Processor <-> data-memory bus for cardinal_dmem.
// Vectors use [0:N-1] ordering so bit 0 is the MSB, as the processor expects.
interface cardinal_dmem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
);
  logic [0:ADDR_W-1] Mem_Addr;
  logic [0:DATA_W-1] Data_Out;
  logic              DmemEn;
  logic              DmemWrEn;
  logic              Scrub_Req;
  logic [0:DATA_W-1] Data_In;
  logic              Dmem_Busy;
  logic              Rd_Valid;

  // Processor side: drives accesses, receives load data and status
  modport master (
    output Mem_Addr, Data_Out, DmemEn, DmemWrEn, Scrub_Req,
    input  Data_In, Dmem_Busy, Rd_Valid
  );

  // Memory side: accepts accesses, returns load data and status
  modport slave (
    input  Mem_Addr, Data_Out, DmemEn, DmemWrEn, Scrub_Req,
    output Data_In, Dmem_Busy, Rd_Valid
  );
endinterface

// File: rtl/cardinal_dmem.sv
// Single-port data memory with registered reads and a scrub engine that
// writes SCRUB_VAL to every word after reset or on request. While the scrub
// runs, Dmem_Busy is high and all processor accesses are dropped.
module cardinal_dmem #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 64,
  parameter logic [0:DATA_W-1] SCRUB_VAL = '0
) (
  input  logic           Clock,
  input  logic           Reset,
  cardinal_dmem_if.slave bus
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  typedef enum logic {
    ST_SCRUB = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [0:DATA_W-1] r_data_in;
  logic              r_rd_valid;
  logic [0:DATA_W-1] r_mem [0:DEPTH-1];

  state_t            w_state_next;
  logic [ADDR_W-1:0] w_ptr_next;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [0:DATA_W-1] w_mem_wdata;
  logic              w_rd_en;

  // Next-state, scrub pointer and array write/read strobes
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_mem_we     = 1'b0;
    w_mem_waddr  = bus.Mem_Addr;
    w_mem_wdata  = bus.Data_Out;
    w_rd_en      = 1'b0;
    case (r_state)
      ST_SCRUB: begin
        // Scrub owns the array port; processor traffic is ignored, and a
        // repeated Scrub_Req does not restart the pointer.
        w_mem_we    = 1'b1;
        w_mem_waddr = r_ptr;
        w_mem_wdata = SCRUB_VAL;
        if (r_ptr == PTR_LAST) begin
          w_state_next = ST_READY;
          w_ptr_next   = '0;
        end else begin
          w_ptr_next = r_ptr + 1'b1;
        end
      end
      ST_READY: begin
        // DmemWrEn is qualified by DmemEn so it may be X while idle.
        w_mem_we = bus.DmemEn & bus.DmemWrEn;
        w_rd_en  = bus.DmemEn & ~bus.DmemWrEn;
        // The access on this edge still completes before scrubbing starts.
        if (bus.Scrub_Req) begin
          w_state_next = ST_SCRUB;
          w_ptr_next   = '0;
        end
      end
      default: begin
        w_state_next = ST_SCRUB;
        w_ptr_next   = '0;
      end
    endcase
  end

  // FSM state and scrub pointer; reset forces a full scrub from word 0
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_SCRUB;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // Array write port; contents are left for the scrub to initialise
  always_ff @(posedge Clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Registered read data and its one-cycle valid strobe
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_data_in  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_en;
      if (w_rd_en) begin
        r_data_in <= r_mem[bus.Mem_Addr];
      end
    end
  end

  assign bus.Data_In   = r_data_in;
  assign bus.Rd_Valid  = r_rd_valid;
  assign bus.Dmem_Busy = (r_state == ST_SCRUB);

endmodule

// File: tb/tb_cardinal_dmem.sv
// Directed bench for cardinal_dmem with a transaction-level reference model.
module tb_cardinal_dmem;

  localparam int AW    = 8;
  localparam int DW    = 64;
  localparam int DEPTH = 256;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  always #5 Clock = ~Clock;

  cardinal_dmem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cardinal_dmem #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .SCRUB_VAL(64'h0)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  // Reference model: a scrub simply empties the memory and opens a window
  // of DEPTH edges during which every access is ignored.
  logic [63:0] m_mem [0:DEPTH-1];
  logic [63:0] m_data;
  logic        m_valid;
  int          m_busy_left;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_busy_left <= DEPTH;
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
    end else if (m_busy_left > 0) begin
      m_busy_left <= m_busy_left - 1;
      m_valid     <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (bus.DmemEn && bus.DmemWrEn) begin
        m_mem[bus.Mem_Addr] <= bus.Data_Out;
      end else if (bus.DmemEn) begin
        m_data  <= m_mem[bus.Mem_Addr];
        m_valid <= 1'b1;
      end
      if (bus.Scrub_Req) begin
        m_busy_left <= DEPTH;
        for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
      end
    end
  end

  bit chk_on = 1'b0;
  int n_vec  = 0;
  int n_err  = 0;

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge Clock) begin
    if (chk_on) begin
      n_vec++;
      if (bus.Data_In !== m_data) begin
        n_err++;
        $display("FAIL model_data t=%0t: got %h want %h", $time, bus.Data_In, m_data);
      end
      if (bus.Rd_Valid !== m_valid) begin
        n_err++;
        $display("FAIL model_valid t=%0t: got %b want %b", $time, bus.Rd_Valid, m_valid);
      end
      if (bus.Dmem_Busy !== (m_busy_left > 0)) begin
        n_err++;
        $display("FAIL model_busy t=%0t: got %b want %b", $time, bus.Dmem_Busy, (m_busy_left > 0));
      end
    end
  end

  task automatic chk64(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", nm, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  // Apply one edge's worth of inputs, starting and ending on a falling edge
  task automatic drive(input logic en, input logic wr, input logic [7:0] a,
                       input logic [63:0] d, input logic sr);
    bus.DmemEn    = en;
    bus.DmemWrEn  = wr;
    bus.Mem_Addr  = a;
    bus.Data_Out  = d;
    bus.Scrub_Req = sr;
    if (en || sr)
      $display("txn t=%0t en=%0b wr=%0b addr=%h data=%h scrub=%0b", $time, en, wr, a, d, sr);
    @(negedge Clock);
  endtask

  // Count edges until Dmem_Busy falls, bounded so a stuck FSM cannot hang
  task automatic busy_window(input string nm);
    int k;
    k = 0;
    while (bus.Dmem_Busy && k < 400) begin
      drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b0);
      k++;
    end
    chk_int(nm, k, DEPTH);
  endtask

  initial begin
    bus.DmemEn    = 1'b0;
    bus.DmemWrEn  = 1'b0;
    bus.Mem_Addr  = '0;
    bus.Data_Out  = '0;
    bus.Scrub_Req = 1'b0;

    // Power-on reset
    #3 Reset = 1'b0;
    #1;
    chk_on = 1'b1;
    chk64("rst_data", bus.Data_In, 64'h0);
    chk1("rst_valid", bus.Rd_Valid, 1'b0);
    chk1("rst_busy", bus.Dmem_Busy, 1'b1);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    busy_window("post_reset_window");

    // Scrubbed contents read back as zero
    drive(1'b1, 1'b0, 8'h00, 64'h0, 1'b0);
    drive(1'b1, 1'b0, 8'h7F, 64'h0, 1'b0);
    drive(1'b1, 1'b0, 8'hFF, 64'h0, 1'b0);
    chk64("read_ff_data", bus.Data_In, 64'h0);
    chk1("read_ff_valid", bus.Rd_Valid, 1'b1);

    // Write followed immediately by read of the same word, then idle hold
    drive(1'b1, 1'b1, 8'h10, 64'hDEADBEEF_01234567, 1'b0);
    chk1("write_no_valid", bus.Rd_Valid, 1'b0);
    drive(1'b1, 1'b0, 8'h10, 64'h0, 1'b0);
    chk64("wr_rd_data", bus.Data_In, 64'hDEADBEEF_01234567);
    chk1("wr_rd_valid", bus.Rd_Valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 8'h55, 64'h0, 1'b0);
      chk64("idle_hold_data", bus.Data_In, 64'hDEADBEEF_01234567);
      chk1("idle_valid", bus.Rd_Valid, 1'b0);
    end

    // Scrub on request: accesses dropped, repeat request ignored,
    // access on the final scrub edge dropped
    drive(1'b1, 1'b1, 8'h20, 64'h1, 1'b0);
    drive(1'b1, 1'b0, 8'h20, 64'h0, 1'b0);
    chk64("pre_scrub_data", bus.Data_In, 64'h1);
    drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b1);
    chk1("scrub_busy_next", bus.Dmem_Busy, 1'b1);
    begin
      int k;
      k = 0;
      while (bus.Dmem_Busy && k < 400) begin
        if (k == 2)        drive(1'b1, 1'b1, 8'h30, 64'hFF, 1'b0);
        else if (k == 3)   drive(1'b1, 1'b0, 8'h20, 64'h0, 1'b0);
        else if (k == 99)  drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b1);
        else if (k == 255) drive(1'b1, 1'b1, 8'h31, 64'h77, 1'b0);
        else               drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b0);
        k++;
        if (k == 10) chk64("scrub_hold_data", bus.Data_In, 64'h1);
      end
      chk_int("scrub_req_window", k, DEPTH);
    end
    drive(1'b1, 1'b0, 8'h20, 64'h0, 1'b0);
    chk64("scrubbed_20", bus.Data_In, 64'h0);
    drive(1'b1, 1'b0, 8'h30, 64'h0, 1'b0);
    chk64("scrubbed_30", bus.Data_In, 64'h0);
    drive(1'b1, 1'b0, 8'h31, 64'h0, 1'b0);
    chk64("final_edge_drop", bus.Data_In, 64'h0);

    // Read coinciding with Scrub_Req completes, then reset mid-scrub
    drive(1'b1, 1'b1, 8'h40, 64'h0000_0000_0000_CAFE, 1'b0);
    drive(1'b1, 1'b0, 8'h40, 64'h0, 1'b1);
    chk64("req_read_data", bus.Data_In, 64'h0000_0000_0000_CAFE);
    chk1("req_read_valid", bus.Rd_Valid, 1'b1);
    chk1("req_read_busy", bus.Dmem_Busy, 1'b1);
    repeat (49) drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b0);
    #2 Reset = 1'b0;
    #1;
    chk64("midscrub_rst_data", bus.Data_In, 64'h0);
    chk1("midscrub_rst_valid", bus.Rd_Valid, 1'b0);
    chk1("midscrub_rst_busy", bus.Dmem_Busy, 1'b1);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    busy_window("rerun_window");
    drive(1'b1, 1'b0, 8'h40, 64'h0, 1'b0);
    chk64("after_rst_40", bus.Data_In, 64'h0);
    chk1("after_rst_valid", bus.Rd_Valid, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
